multicycle_core: RTL

Parametrised multicycle successor to the single-cycle datapath: executes the same MIPS-subset instruction encoding, but through a finite-state sequencer that reuses one ALU and one unified memory port over several cycles per instruction. Contains PC, instruction/data latches, 32-entry register file, ALU and control FSM. Memory is external and accessed through a req/ready handshake, so instruction fetch and data access may stall for any number of cycles. Sits at the CPU top level in place of the single-cycle datapath.

---
 rtl/multicycle_core.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: one ALU and one unified memory port reused
// across several cycles per instruction under a control sequencer.
// Ports:
//   CLK, rst           clock, asynchronous active-high reset
//   mem_req/mem_we     memory request / write strobe (registered)
//   mem_addr/mem_wdata byte address and store data (registered)
//   mem_rdata/ready    read data and access completion
//   alu_out            registered ALU result
//   result             last value written to the register file
//   halted             core stopped on an illegal instruction
//   retired            completed instruction count (wraps)
module multicycle_core #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ready,
    output logic [N-1:0]  alu_out,
    output logic [N-1:0]  result,
    output logic          halted,
    output logic [31:0]   retired
);

    localparam int unsigned NREGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] pc, pc_next;
    logic [31:0]  ir, ir_next;
    logic [N-1:0] a, a_next, b, b_next, mdr, mdr_next, alu_next;
    logic [N-1:0] rf [NREGS];
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;
    logic         retire;
    logic         req_next, we_next;
    logic [N-1:0] addr_next, wdata_next;

    logic [5:0]   opcode, funct;
    logic [4:0]   rs, rt, rd;
    logic [N-1:0] signimm;
    logic         done;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign signimm = {{(N-16){ir[15]}}, ir[15:0]};
    assign done    = mem_req & mem_ready;

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state, datapath and memory-port next values
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        a_next     = a;
        b_next     = b;
        mdr_next   = mdr;
        alu_next   = alu_out;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        retire     = 1'b0;
        req_next   = 1'b0;
        we_next    = 1'b0;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;

        case (state)
            S_FETCH: begin
                if (done) begin
                    ir_next    = mem_rdata[31:0];
                    pc_next    = pc + N'(4);
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                a_next = rf[rs];
                b_next = rf[rt];
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_next = S_RTYPE_EX;
                            FN_JR:   state_next = S_JUMP;
                            default: state_next = S_HALT;
                        endcase
                    end
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    OP_J, OP_JAL: state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_RTYPE_EX: begin
                case (funct)
                    FN_ADD:  alu_next = a + b;
                    FN_SUB:  alu_next = a - b;
                    FN_AND:  alu_next = a & b;
                    FN_OR:   alu_next = a | b;
                    FN_SLT:  alu_next = N'($signed(a) < $signed(b));
                    default: alu_next = '0;
                endcase
                state_next = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_next   = a + signimm;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMADR: begin
                alu_next   = a + signimm;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (done) begin
                    mdr_next   = mem_rdata;
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we      = 1'b1;
                rf_wdata   = mdr;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                if (done) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                // pc already holds PC+4 here
                if (a == b) pc_next = pc + {signimm[N-3:0], 2'b00};
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                if (opcode == OP_RTYPE) pc_next = a;
                else                    pc_next = {pc[N-1:28], ir[25:0], 2'b00};
                if (opcode == OP_JAL) begin
                    rf_we    = 1'b1;
                    rf_waddr = 5'd31;
                    rf_wdata = pc;
                end
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase

        // Memory port is registered from the upcoming state, so it holds while stalled
        case (state_next)
            S_FETCH: begin
                req_next  = 1'b1;
                addr_next = pc_next;
            end
            S_MEMRD: begin
                req_next  = 1'b1;
                addr_next = alu_next;
            end
            S_MEMWR: begin
                req_next   = 1'b1;
                we_next    = 1'b1;
                addr_next  = alu_next;
                wdata_next = b_next;
            end
            default: ;
        endcase
    end

    // Datapath, register file and output registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            mdr       <= '0;
            alu_out   <= '0;
            result    <= '0;
            halted    <= 1'b0;
            retired   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            pc        <= pc_next;
            ir        <= ir_next;
            a         <= a_next;
            b         <= b_next;
            mdr       <= mdr_next;
            alu_out   <= alu_next;
            halted    <= (state_next == S_HALT);
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            if (retire) retired <= retired + 32'd1;
            if (rf_we) begin
                result <= rf_wdata;
                if (rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
            end
        end
    end

endmodule
